// File: rtl/pwm_duty_sequencer.sv
// Compare-register sequencer for the PWM generator: accepts phase/width targets over req/ack
// and ramps cr2 toward the target width, updating cr1/cr2 only at period boundaries.
module pwm_duty_sequencer #(
  parameter int unsigned PERIOD = 5000,
  parameter int unsigned W      = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req,
  input  logic [W-1:0] target_phase,
  input  logic [W-1:0] target_width,
  input  logic [W-1:0] step,
  output logic         ack,
  output logic         busy,
  output logic         done,
  output logic         period_start,
  output logic [W-1:0] cr1,
  output logic [W-1:0] cr2
);

  localparam int unsigned CntW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CntW-1:0] CntLast  = CntW'(PERIOD - 1);
  localparam logic [W-1:0]    PeriodW  = W'(PERIOD);
  localparam logic [W-1:0]    PhaseMax = W'(PERIOD - 1);

  typedef enum logic [1:0] {StIdle, StArmed, StRamp} state_e;

  state_e         state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]   phase_t_q, phase_t_d;
  logic [W-1:0]   width_t_q, width_t_d;
  logic [W-1:0]   step_q, step_d;
  logic [W-1:0]   width_cur_q, width_cur_d;
  logic [W-1:0]   cr1_q, cr1_d;
  logic [W-1:0]   cr2_q, cr2_d;
  logic           ack_q, ack_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           ps_q, ps_d;

  logic           boundary_next;
  logic           accept;
  logic [W-1:0]   phase_c, width_room, width_c;
  logic [W-1:0]   diff, width_step;

  // Registered outputs are loaded on the edge entering the boundary cycle, so they become
  // visible while cnt == PERIOD-1, all together.
  always_comb begin
    cnt_d         = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
    boundary_next = (cnt_d == CntLast);
    accept        = (state_q == StIdle) && req && !busy_q;
  end

  always_comb begin
    phase_c    = (target_phase > PhaseMax) ? PhaseMax : target_phase;
    width_room = PeriodW - phase_c;
    width_c    = (target_width > width_room) ? width_room : target_width;
  end

  always_comb begin
    diff = (width_t_q >= width_cur_q) ? (width_t_q - width_cur_q) : (width_cur_q - width_t_q);
    if (step_q == '0 || step_q >= diff) begin
      width_step = width_t_q;
    end else if (width_t_q > width_cur_q) begin
      width_step = width_cur_q + step_q;
    end else begin
      width_step = width_cur_q - step_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_t_d   = phase_t_q;
    width_t_d   = width_t_q;
    step_d      = step_q;
    width_cur_d = width_cur_q;
    cr1_d       = cr1_q;
    cr2_d       = cr2_q;
    done_d      = 1'b0;
    ack_d       = accept;
    ps_d        = boundary_next;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          phase_t_d = phase_c;
          width_t_d = width_c;
          step_d    = step;
          state_d   = StArmed;
        end
      end
      StArmed, StRamp: begin
        if (boundary_next) begin
          cr1_d       = phase_t_q;
          width_cur_d = width_step;
          cr2_d       = phase_t_q + width_step;
          if (width_step == width_t_q) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StRamp;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Hold busy through the done cycle so it drops on the edge after done.
    busy_d = (state_d != StIdle) || done_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      phase_t_q   <= '0;
      width_t_q   <= '0;
      step_q      <= '0;
      width_cur_q <= '0;
      cr1_q       <= '0;
      cr2_q       <= '0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ps_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_t_q   <= phase_t_d;
      width_t_q   <= width_t_d;
      step_q      <= step_d;
      width_cur_q <= width_cur_d;
      cr1_q       <= cr1_d;
      cr2_q       <= cr2_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ps_q        <= ps_d;
    end
  end

  assign ack          = ack_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign period_start = ps_q;
  assign cr1          = cr1_q;
  assign cr2          = cr2_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer: a width-ramp model pushes expected boundary updates
// into a scoreboard queue that is popped at each period_start.
module tb_pwm_duty_sequencer;

  localparam int unsigned PERIOD = 5000;
  localparam int unsigned W      = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic         req;
  logic [W-1:0] target_phase;
  logic [W-1:0] target_width;
  logic [W-1:0] step;
  logic         ack;
  logic         busy;
  logic         done;
  logic         period_start;
  logic [W-1:0] cr1;
  logic [W-1:0] cr2;

  pwm_duty_sequencer #(
    .PERIOD(PERIOD),
    .W     (W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .target_phase(target_phase),
    .target_width(target_width),
    .step        (step),
    .ack         (ack),
    .busy        (busy),
    .done        (done),
    .period_start(period_start),
    .cr1         (cr1),
    .cr2         (cr2)
  );

  always #10 clock = ~clock;

  typedef struct {
    logic [W-1:0] cr1;
    logic [W-1:0] cr2;
    logic         done;
  } exp_t;

  exp_t sb[$];
  int   mw;
  int   compared   = 0;
  int   mismatched = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model of the clamp and step rule; one queue entry per boundary update.
  task automatic plan(input int ph, input int wd, input int st);
    int   pt, wt, df, nx;
    exp_t e;
    pt = (ph > PERIOD - 1) ? PERIOD - 1 : ph;
    wt = (wd > PERIOD - pt) ? PERIOD - pt : wd;
    do begin
      df = (wt >= mw) ? wt - mw : mw - wt;
      if (st == 0 || st >= df) nx = wt;
      else if (wt > mw)        nx = mw + st;
      else                     nx = mw - st;
      e.cr1  = W'(pt);
      e.cr2  = W'(pt + nx);
      e.done = (nx == wt);
      sb.push_back(e);
      mw = nx;
    end while (mw != wt);
  endtask

  task automatic issue(input int ph, input int wd, input int st);
    bit got;
    got          = 1'b0;
    target_phase = W'(ph);
    target_width = W'(wd);
    step         = W'(st);
    req          = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ack === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check("ack_seen", 32'(got), 1);
    check("busy_with_ack", 32'(busy), 1);
    req = 1'b0;
    plan(ph, wd, st);
  endtask

  task automatic wait_ps(output int n, output bit stable);
    logic [W-1:0] c1, c2;
    c1     = cr1;
    c2     = cr2;
    stable = 1'b1;
    n      = 0;
    do begin
      tick();
      n++;
      if (!period_start && (cr1 !== c1 || cr2 !== c2 || done !== 1'b0)) stable = 1'b0;
    end while (!period_start && n < 6000);
    check("period_start_seen", 32'(period_start), 1);
  endtask

  task automatic drain(input int count, input bit intrude);
    int   n;
    bit   st;
    bit   any;
    exp_t e;
    for (int k = 0; k < count && sb.size() > 0; k++) begin
      wait_ps(n, st);
      check("cr_stable_between", 32'(st), 1);
      e = sb.pop_front();
      check("cr1_at_boundary", 32'(cr1), 32'(e.cr1));
      check("cr2_at_boundary", 32'(cr2), 32'(e.cr2));
      check("done_at_boundary", 32'(done), 32'(e.done));
      check("busy_at_boundary", 32'(busy), 1);
      if (intrude && k == 0) begin
        target_phase = 16'd2000;
        target_width = 16'd50;
        step         = 16'd0;
        req          = 1'b1;
        any          = 1'b0;
        repeat (5) begin
          tick();
          if (ack !== 1'b0) any = 1'b1;
        end
        req = 1'b0;
        check("no_ack_while_busy", 32'(any), 0);
      end
    end
    if (sb.size() == 0) begin
      tick();
      check("busy_after_done", 32'(busy), 0);
      check("done_one_cycle", 32'(done), 0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    mw    = 0;
    sb.delete();
  endtask

  initial begin
    int n;
    bit st;
    reset        = 1'b1;
    req          = 1'b0;
    target_phase = '0;
    target_width = '0;
    step         = '0;
    mw           = 0;
    repeat (3) tick();
    check("rst_ack", 32'(ack), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_period_start", 32'(period_start), 0);
    check("rst_cr1", 32'(cr1), 0);
    check("rst_cr2", 32'(cr2), 0);

    // First period_start lands at cnt 4999, then every 5000 cycles.
    reset = 1'b0;
    wait_ps(n, st);
    check("first_ps_latency", 32'(n), PERIOD - 1);
    check("idle_stable", 32'(st), 1);
    wait_ps(n, st);
    check("ps_repeat", 32'(n), PERIOD);

    // Jump from width 0.
    repeat (1000) tick();
    issue(1000, 2500, 0);
    tick();
    check("ack_one_cycle", 32'(ack), 0);
    drain(1000, 1'b0);

    // Ramp 0 -> 1000 by 300, with a rejected request mid-ramp.
    do_reset();
    issue(0, 1000, 300);
    drain(1000, 1'b1);

    // Clamping of phase and width.
    issue(6000, 100, 0);
    drain(1000, 1'b0);
    issue(4000, 3000, 0);
    drain(1000, 1'b0);

    // Request in an idle boundary cycle: accepted, applied one full period later.
    wait_ps(n, st);
    target_phase = 16'd100;
    target_width = 16'd200;
    step         = 16'd0;
    req          = 1'b1;
    tick();
    req = 1'b0;
    check("boundary_req_ack", 32'(ack), 1);
    check("boundary_req_cr1_hold", 32'(cr1), 4000);
    check("boundary_req_cr2_hold", 32'(cr2), 5000);
    plan(100, 200, 0);
    repeat (100) tick();
    check("boundary_req_cr2_hold_late", 32'(cr2), 5000);
    drain(1000, 1'b0);

    // Reset mid-ramp, then a fresh ramp must start from width 0.
    do_reset();
    issue(0, 1000, 100);
    drain(3, 1'b0);
    reset = 1'b1;
    tick();
    check("midrst_cr1", 32'(cr1), 0);
    check("midrst_cr2", 32'(cr2), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_ack", 32'(ack), 0);
    reset = 1'b0;
    sb.delete();
    mw = 0;
    issue(0, 1000, 500);
    drain(1000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pwm_duty_sequencer.md
# pwm_duty_sequencer

Controller that sits in front of the 10 kHz PWM generator and drives its two compare registers. Software or upstream logic hands it a target pulse phase and width through a req/ack handshake. The sequencer then updates the compare registers only at PWM period boundaries, so the output never glitches mid-period. The width ramps toward the target by a programmable step each period, giving soft start and fade.

## Interface
Parameters:
- PERIOD, 5000: PWM period in clock cycles (50 MHz / 5000 = 10 kHz); must match the generator's counter wrap.
- W, 16: width of all compare, target and step values.

Ports:
- clock  in  1  system clock (50 MHz); all logic on posedge clock.
- reset  in  1  synchronous, active-high; sampled on posedge clock.
- req  in  1  new-setting request; held high until ack.
- target_phase  in  W  rising-edge position (becomes cr1).
- target_width  in  W  high time in cycles (cr2 = cr1 + width).
- step  in  W  width change per period; 0 = jump directly to target.
- ack  out  1  one-cycle pulse: request accepted and targets latched.
- busy  out  1  high from acceptance until the final update is applied.
- done  out  1  one-cycle pulse in the boundary cycle that applies the final width.
- period_start  out  1  one-cycle pulse when the internal period counter equals PERIOD-1 (the boundary).
- cr1  out  W  compare register 1 to the PWM generator.
- cr2  out  W  compare register 2 to the PWM generator.

## Operation
- Internal period counter cnt runs from 0 to PERIOD-1 and wraps to 0. It comes out of reset in the same cycle as the generator's counter.
- The boundary cycle is cnt == PERIOD-1. cr1 and cr2 change only in boundary cycles, so new values take effect from count 0 of the next period.
- The state machine has three states: IDLE, ARMED and RAMP.
- IDLE:
  - busy = 0.
  - If req = 1, latch the clamped targets, pulse ack and go to ARMED.
- Clamping is applied at latch:
  - phase_t = min(target_phase, PERIOD-1).
  - width_t = min(target_width, PERIOD - phase_t).
- ARMED, at the next boundary:
  - cr1 <= phase_t.
  - Step the width once using the rule below.
  - cr2 <= phase_t + width_cur_next.
  - If width_cur_next == width_t, pulse done and go to IDLE; otherwise go to RAMP.
- RAMP: at each boundary, step the width and update cr2 the same way; when the target is reached, pulse done and go to IDLE.
- Step rule (unsigned, W bits):
  - diff = |width_t - width_cur|.
  - If step == 0 or step >= diff, width_cur_next = width_t.
  - Otherwise, width_cur_next = width_cur ± step, toward width_t.
- width_cur persists across requests, so each new request ramps from the currently applied width. cr2 never exceeds PERIOD, so no overflow occurs.
- req is ignored while busy (no ack). Latched targets cannot be changed mid-ramp.
- A req arriving in a boundary cycle while in IDLE:
  - It is accepted (ack pulses).
  - It cannot affect that boundary's outputs.
  - The first update happens one full period later.

## Timing
- Reset values:
  - cr1 = 0, cr2 = 0, width_cur = 0, cnt = 0.
  - ack = 0, busy = 0, done = 0, period_start = 0.
  - State = IDLE.
- Reset asserted mid-ramp aborts immediately, returns all of the above to reset values on the next edge, and drops any pending target.
- ack rises on the clock edge after req is sampled high in IDLE and lasts exactly one cycle.
- busy rises with ack and falls on the edge after done.
- The latency from ack to the first cr update is 1 to PERIOD cycles, set by the cnt position.
- A ramp of N steps completes in N boundaries (N = ceil(diff/step), or 1 when step == 0).
- All outputs are registered; there are no combinational paths from inputs to outputs.
- period_start, done and the cr1/cr2 updates coincide in the same cycle.

## Test plan
- Reset, then release:
  - All outputs are 0.
  - period_start first pulses PERIOD-1 = 4999 cycles after reset is released (at cnt 4999).
  - It repeats every 5000 cycles.
- Jump, from IDLE with width_cur = 0:
  - Apply req with phase 1000, width 2500, step 0.
  - ack pulses once.
  - At the next boundary cr1 = 1000, cr2 = 3500 and done pulses.
  - busy is high only from ack until the edge after done.
- Ramp:
  - From phase 0, width 0, apply req with phase 0, width 1000, step 300.
  - cr2 takes the values 300, 600, 900, 1000 on 4 successive boundaries.
  - done pulses with the value 1000.
  - cr2 is stable between boundaries.
- Clamp:
  - Apply req with phase 6000, width 100.
  - Result: cr1 = 4999, cr2 = 5000.
  - Apply req with phase 4000, width 3000.
  - Result: cr2 = 5000.
- Busy and boundary edge cases:
  - A second req during a ramp gets no ack and leaves the latched targets unchanged.
  - A req in IDLE in a boundary cycle is acked, but cr1 and cr2 keep their old values until the following boundary.
- Reset mid-ramp:
  - Start a ramp with step 100 to width 1000.
  - Assert reset after 3 boundaries (cr2 = 300).
  - On the next edge cr1 = cr2 = 0, busy = 0 and the state is IDLE.
  - A new req ramps from width 0.
